// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: owns the PC, issues credit-limited imem fetches and buffers in-order responses for decode.
// Optional misaligned-redirect trap (HALT state, sticky misalign) enabled by defining PC_MISALIGN_TRAP_EN.
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [1:0]  pc_source,
  input  logic [31:0] jalr_tgt,
  input  logic [31:0] branch_tgt,
  input  logic [31:0] jal_tgt,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic        misalign
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [1:0] HOLD = 2'd0, FETCH = 2'd1;
`ifdef PC_MISALIGN_TRAP_EN
  localparam logic [1:0] HALT = 2'd2;
`endif
  logic [1:0]    state;
  logic [31:0]   fetch_pc, raw_tgt, tgt, last_instr, last_pc;
  logic [CW-1:0] outstanding, buf_count, drop_cnt;
  logic [AW-1:0] tag_wr, tag_rd, buf_wr, buf_rd;
  logic [31:0]   tag_mem   [BUF_DEPTH];
  logic [31:0]   instr_mem [BUF_DEPTH];
  logic [31:0]   pc_mem    [BUF_DEPTH];
  logic          redirect_now, grant, resp, drop, wr, pop;
  assign redirect_now = redirect_valid && pc_source != 2'b00;
  assign raw_tgt = pc_source == 2'b01 ? jalr_tgt : pc_source == 2'b10 ? branch_tgt : jal_tgt;
  assign imem_req = state == FETCH && !redirect_now && (outstanding + buf_count) < CW'(BUF_DEPTH);
  assign imem_addr = fetch_pc;
  assign grant = imem_req && imem_gnt;
  // responses with nothing outstanding are strays (e.g. issued before a reset)
  assign resp = imem_rvalid && outstanding != '0;
  assign drop = resp && drop_cnt != '0;
  assign wr = resp && !drop && !redirect_now && state == FETCH;
  assign pop = if_valid && if_ready && !redirect_now;
  assign if_valid = buf_count != '0;
  assign if_instr = if_valid ? instr_mem[buf_rd] : last_instr;
  assign if_pc = if_valid ? pc_mem[buf_rd] : last_pc;
`ifdef PC_MISALIGN_TRAP_EN
  logic trap;
  assign tgt = raw_tgt;
  assign trap = redirect_now && raw_tgt[1:0] != 2'b00;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) misalign <= 1'b0;
    else if (trap) misalign <= 1'b1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= HOLD;
    else if (trap) state <= HALT;
    else if (state == HOLD) state <= FETCH;
`else
  assign tgt = raw_tgt & ~32'h3;
  assign misalign = 1'b0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= HOLD;
    else if (state == HOLD) state <= FETCH;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      buf_count   <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      buf_wr      <= '0;
      buf_rd      <= '0;
      last_instr  <= '0;
      last_pc     <= RESET_PC;
    end else begin
      fetch_pc    <= redirect_now ? tgt : grant ? fetch_pc + 32'd4 : fetch_pc;
      tag_wr      <= grant ? tag_wr + AW'(1) : tag_wr;
      tag_rd      <= resp ? tag_rd + AW'(1) : tag_rd;
      outstanding <= outstanding + CW'(grant) - CW'(resp);
      // everything still in flight after a redirect is stale
      drop_cnt    <= redirect_now ? outstanding - CW'(resp) : drop_cnt - CW'(drop);
      buf_count   <= redirect_now ? '0 : buf_count + CW'(wr) - CW'(pop);
      buf_wr      <= redirect_now ? '0 : wr ? buf_wr + AW'(1) : buf_wr;
      buf_rd      <= redirect_now ? '0 : pop ? buf_rd + AW'(1) : buf_rd;
      if (if_valid) begin
        last_instr <= if_instr;
        last_pc    <= if_pc;
      end
    end
  always_ff @(posedge clk) begin
    if (grant) tag_mem[tag_wr] <= fetch_pc;
    if (wr) begin
      instr_mem[buf_wr] <= imem_rdata;
      pc_mem[buf_wr]    <= tag_mem[tag_rd];
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: scoreboard bench for pc_fetch_unit with an in-order imem responder model.
module tb_pc_fetch_unit;
  localparam logic [31:0] KEY = 32'hA5A5_A5A5;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [1:0]  pc_source = 2'b00;
  logic [31:0] jalr_tgt = '0, branch_tgt = '0, jal_tgt = '0;
  logic        imem_req, imem_gnt = 1'b0, imem_rvalid = 1'b0;
  logic [31:0] imem_addr, imem_rdata = '0;
  logic        if_valid, if_ready = 1'b0, misalign;
  logic [31:0] if_instr, if_pc;
  int          vectors = 0, miscompares = 0;
  logic [63:0] resp_q[$];
  logic [63:0] exp_q[$];
  int          epoch = 0, grants = 0;
  logic [31:0] exp_addr = '0, last_pc = '0, s_tgt = '0;
  logic        s_gnt = 1'b1, s_rdy = 1'b1, s_hold = 1'b0, s_redir = 1'b0, last_req = 1'b0;
  logic [1:0]  s_src = 2'b00;

  pc_fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .redirect_valid(redirect_valid), .pc_source(pc_source),
    .jalr_tgt(jalr_tgt), .branch_tgt(branch_tgt), .jal_tgt(jal_tgt),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // one cycle: drive staged inputs at negedge, observe at +1, update the model
  task automatic tick();
    logic [63:0] r, e;
    bit rv, redir;
    @(negedge clk);
    rv = 1'b0;
    imem_gnt = s_gnt;
    if_ready = s_rdy;
    redirect_valid = s_redir;
    pc_source = s_src;
    jalr_tgt = s_src == 2'b01 ? s_tgt : 32'hDEAD_0004;
    branch_tgt = s_src == 2'b10 ? s_tgt : 32'hDEAD_0008;
    jal_tgt = s_src == 2'b11 ? s_tgt : 32'hDEAD_000C;
    if (!s_hold && resp_q.size() > 0) begin
      r = resp_q.pop_front();
      rv = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata = r[31:0] ^ KEY;
    end else imem_rvalid = 1'b0;
    #1;
    redir = s_redir && s_src != 2'b00;
    last_req = imem_req;
    if (if_valid && if_ready && !redir) begin
      check("sb_avail", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("if_pc", if_pc, e[31:0]);
        check("if_instr", if_instr, e[63:32]);
        last_pc = e[31:0];
      end
    end
    if (redir) check("req_in_redirect", imem_req, 0);
    if (imem_req && imem_gnt) begin
      check("imem_addr", imem_addr, exp_addr);
      resp_q.push_back({32'(epoch), imem_addr});
      exp_addr += 32'd4;
      grants++;
    end
    if (rv && !redir && r[63:32] == 32'(epoch)) exp_q.push_back({r[31:0] ^ KEY, r[31:0]});
    if (redir) begin
      exp_q.delete();
      epoch++;
      exp_addr = s_tgt & ~32'h3;
    end
    s_redir = 1'b0;
  endtask

  task automatic do_reset(input bit stray);
    @(negedge clk);
    rst_n = 1'b0;
    imem_rvalid = 1'b0;
    imem_gnt = 1'b0;
    redirect_valid = 1'b0;
    resp_q.delete();
    exp_q.delete();
    epoch++;
    exp_addr = 32'h0;
    #1;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 32'h0);
    check("rst_valid", if_valid, 0);
    check("rst_instr", if_instr, 32'h0);
    check("rst_pc", if_pc, 32'h0);
    check("rst_misalign", misalign, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    imem_rvalid = stray;
    imem_rdata = 32'h1BAD_BEEF;
    #1;
    check("hold_req", imem_req, 0);
  endtask

  task automatic drain();
    s_gnt = 1'b0;
    s_rdy = 1'b1;
    repeat (6) tick();
    check("drained", exp_q.size(), 0);
    check("idle_valid", if_valid, 0);
  endtask

  initial begin
    do_reset(1'b0);
    tick();
    check("first_req", last_req, 1);
    repeat (30) tick();
    drain();
    check("hold_pc", if_pc, last_pc);
    // backpressure: credit must stop fetching after BUF_DEPTH grants
    s_gnt = 1'b1;
    s_rdy = 1'b0;
    grants = 0;
    repeat (10) tick();
    check("full_grants", grants, 2);
    check("full_req", last_req, 0);
    check("full_valid", if_valid, 1);
    s_rdy = 1'b1;
    repeat (8) tick();
    drain();
    // branch redirect with two stale requests in flight
    s_gnt = 1'b1;
    s_hold = 1'b1;
    grants = 0;
    repeat (3) tick();
    check("inflight", grants, 2);
    s_redir = 1'b1; s_src = 2'b10; s_tgt = 32'h100;
    tick();
    tick();
    check("br_addr", imem_addr, 32'h100);
    check("br_valid", if_valid, 0);
    s_hold = 1'b0;
    for (int i = 0; i < 10 && !if_valid; i++) tick();
    check("br_wait", if_valid, 1);
    check("br_pc", if_pc, 32'h100);
    drain();
    // jal redirect coinciding with a response, one more still in flight
    s_gnt = 1'b1;
    s_hold = 1'b1;
    repeat (3) tick();
    s_hold = 1'b0;
    s_redir = 1'b1; s_src = 2'b11; s_tgt = 32'h40;
    tick();
    tick();
    check("jal_addr", imem_addr, 32'h40);
    check("jal_req", last_req, 1);
    tick();
    check("jal_valid_n2", if_valid, 0);
    tick();
    check("jal_valid_n3", if_valid, 1);
    check("jal_pc", if_pc, 32'h40);
    check("jal_instr", if_instr, 32'h40 ^ KEY);
    drain();
    // misaligned jalr target
    s_gnt = 1'b1;
    s_redir = 1'b1; s_src = 2'b01; s_tgt = 32'h102;
    tick();
    tick();
`ifdef PC_MISALIGN_TRAP_EN
    check("misalign", misalign, 1);
    check("halt_req", last_req, 0);
    grants = 0;
    repeat (5) tick();
    check("halt_grants", grants, 0);
    check("misalign_sticky", misalign, 1);
`else
    check("misalign", misalign, 0);
    check("jalr_addr", imem_addr, 32'h100);
    check("jalr_req", last_req, 1);
    repeat (10) tick();
`endif
    // mid-stream reset followed by a stray response
    s_gnt = 1'b1;
    repeat (3) tick();
    do_reset(1'b1);
    tick();
    check("rst2_first_req", last_req, 1);
    check("stray_ignored", if_valid, 0);
    repeat (12) tick();
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
